alu32: RTL and testbench
========================

// Module: alu32
// PURPOSE
//  32-bit registered integer ALU for the datapath execute stage.
//  - Add/subtract with carry-in, bitwise XOR/AND/OR/NOR, logical shifts, arithmetic shift right.
//  - Produces result, carry-out, zero, negative and overflow flags.
//  - All outputs are registered on one clock with a synchronous active-high reset.
// PARAMETERS
//  none (width fixed at 32)
// PORTS
//  clk     in   1   single clock; all state updates on rising edge
//  rst     in   1   synchronous, active-high reset
//  A       in   32  operand A
//  B       in   32  operand B (shift amount = B[4:0] for shifts)
//  Cin     in   1   carry-in (ADD) / borrow-in (SUB)
//  Cout    out  1   carry-out of the adder; 0 for non-arithmetic ops
//  sub     in   1   1 = subtract when opcode=000, ignored otherwise
//  opcode  in   3   operation select
//  result  out  32  operation result
//  z       out  1   zero flag: result == 0
//  n       out  1   negative flag: result[31]
//  o       out  1   signed overflow flag; 0 for non-arithmetic ops
// BEHAVIOUR
//  - Interface: one clock, synchronous active-high reset.
//  - Reset: on a rising clk edge with rst=1, result=0, Cout=0, o=0, n=0, z=0.
//    - z is forced to 0 during reset; it is not derived from result.
//    - Reset has priority over the computation in that cycle.
//  - Latency: 1 cycle.
//    - Inputs are sampled at a rising edge; outputs reflect them after that edge.
//    - No handshake; a new op is accepted every cycle.
//  - Opcodes:
//    - 000 ADD/SUB:
//      - sub=0: {Cout,result} = A + B + Cin (33-bit sum).
//      - sub=1: {Cout,result} = A + ~B + ~Cin, i.e. A - B - Cin.
//        Cout=1 means no borrow.
//    - 001 XOR: A ^ B
//    - 010 AND: A & B
//    - 011 OR:  A | B
//    - 100 NOR: ~(A | B)
//    - 101 SL:  A << B[4:0] (logical, zero fill)
//    - 110 SR:  A >> B[4:0] (logical, zero fill)
//    - 111 SRA: A >>> B[4:0] (sign fill)
//  - Overflow o (opcode 000 only):
//    - ADD: A[31]==B[31] and result[31]!=A[31].
//    - SUB: A[31]!=B[31] and result[31]!=A[31].
//    - Any other opcode: o=0.
//  - Cout is 0 for opcodes 001..111.
//  - n = result[31] and z = (result==0) for every opcode; computed from the new result in the same cycle.
//  - Shift amounts are modulo 32; B[31:5] are ignored.
//    - Shift by 0 returns A unchanged.
//  - Wrap-around:
//    - 0xFFFFFFFF + 1 -> result 0, Cout=1, z=1, o=0.
//    - 0x7FFFFFFF + 1 -> 0x80000000, o=1, n=1.
// TESTING
//  - ADD: A=5, B=10, Cin=0, sub=0 -> next cycle result=15, Cout=0, z=0, n=0, o=0.
//  - ADD with carry: A=6, B=5, Cin=1 -> result=12.
//    SUB: A=6, B=5, Cin=0, sub=1 -> result=1, Cout=1.
//    SUB: A=5, B=6 -> result=0xFFFFFFFF, n=1, Cout=0.
//  - Logic ops:
//    - XOR 5^9 -> 12.
//    - AND 6&10 -> 2.
//    - OR 7|11 -> 15.
//    - NOR 5,9 -> 0xFFFFFFF2, n=1.
//    - All with Cout=0, o=0.
//  - Shifts:
//    - SL A=7, B=12 -> 0x00007000.
//    - SR A=7, B=12 -> 0, z=1.
//    - SRA A=0x80000000, B=4 -> 0xF8000000.
//  - Overflow/wrap:
//    - ADD 0x7FFFFFFF+1 -> o=1, n=1.
//    - ADD 0xFFFFFFFF+1 -> result 0, z=1, Cout=1.
//    - SUB 0x80000000-1 -> o=1.
//  - Reset: assert rst mid-stream with nonzero operands -> next edge all outputs 0.
//    Deassert -> the following edge computes normally.

Source files
------------

// File: rtl/alu32.sv
// 32-bit registered integer ALU for the execute stage.
// Add/sub with carry, logic ops and shifts; result and flags registered.
module alu32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  input  logic        sub,
  input  logic [2:0]  opcode,
  output logic [31:0] result,
  output logic        Cout,
  output logic        z,
  output logic        n,
  output logic        o
);

  typedef enum logic [2:0] {
    OP_ARITH = 3'b000,
    OP_XOR   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_NOR   = 3'b100,
    OP_SL    = 3'b101,
    OP_SR    = 3'b110,
    OP_SRA   = 3'b111
  } op_e;

  logic [31:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        o_q, o_d;

  logic [31:0] b_x;
  logic        c_x;
  logic [32:0] sum;
  logic [4:0]  shamt;

  // Subtract is A + ~B + ~Cin, so Cout=1 means no borrow.
  assign b_x   = sub ? ~B : B;
  assign c_x   = sub ? ~Cin : Cin;
  assign sum   = {1'b0, A} + {1'b0, b_x} + {32'd0, c_x};
  assign shamt = B[4:0];

  always_comb begin
    result_d = '0;
    cout_d   = 1'b0;
    o_d      = 1'b0;
    unique case (op_e'(opcode))
      OP_ARITH: begin
        result_d = sum[31:0];
        cout_d   = sum[32];
        o_d      = (A[31] == b_x[31]) && (sum[31] != A[31]);
      end
      OP_XOR:  result_d = A ^ B;
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_NOR:  result_d = ~(A | B);
      OP_SL:   result_d = A << shamt;
      OP_SR:   result_d = A >> shamt;
      OP_SRA:  result_d = 32'($signed(A) >>> shamt);
      default: result_d = '0;
    endcase
    z_d = (result_d == 32'd0);
    n_d = result_d[31];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      o_q      <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      z_q      <= z_d;
      n_q      <= n_d;
      o_q      <= o_d;
    end
  end

  assign result = result_q;
  assign Cout   = cout_q;
  assign z      = z_q;
  assign n      = n_q;
  assign o      = o_q;

endmodule

// File: tb/tb_alu32.sv
// Directed-vector bench for alu32.
// Each vector checks result and the {Cout,z,n,o} flag set.
module tb_alu32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        sub;
  logic [2:0]  opcode;
  logic [31:0] result;
  logic        Cout;
  logic        z;
  logic        n;
  logic        o;

  int checks = 0;
  int errors = 0;

  alu32 dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .sub    (sub),
    .opcode (opcode),
    .result (result),
    .Cout   (Cout),
    .z      (z),
    .n      (n),
    .o      (o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one op, clock it, then check result and {Cout,z,n,o}.
  task automatic run(input string tag,
                     input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic cin,
                     input logic sb,
                     input logic [31:0] er,
                     input logic [3:0] ef);
    opcode = op;
    A      = a;
    B      = b;
    Cin    = cin;
    sub    = sb;
    @(posedge clk);
    #1;
    chk({tag, ".res"}, result, er);
    chk({tag, ".flg"}, {28'd0, Cout, z, n, o}, {28'd0, ef});
  endtask

  initial begin
    rst    = 1'b1;
    A      = '0;
    B      = '0;
    Cin    = 1'b0;
    sub    = 1'b0;
    opcode = 3'b000;
    @(posedge clk);
    #1;
    chk("rst.res", result, 32'd0);
    chk("rst.flg", {28'd0, Cout, z, n, o}, 32'd0);
    rst = 1'b0;

    //                                                       {C,z,n,o}
    run("add",     3'b000, 32'd5,        32'd10, 0, 0, 32'd15,        4'b0000);
    run("addc",    3'b000, 32'd6,        32'd5,  1, 0, 32'd12,        4'b0000);
    run("sub",     3'b000, 32'd6,        32'd5,  0, 1, 32'd1,         4'b1000);
    run("subneg",  3'b000, 32'd5,        32'd6,  0, 1, 32'hFFFFFFFF,  4'b0010);
    run("subb",    3'b000, 32'd6,        32'd5,  1, 1, 32'd0,         4'b1100);
    run("xor",     3'b001, 32'd5,        32'd9,  1, 0, 32'd12,        4'b0000);
    run("and",     3'b010, 32'd6,        32'd10, 0, 0, 32'd2,         4'b0000);
    run("or",      3'b011, 32'd7,        32'd11, 0, 1, 32'd15,        4'b0000);
    run("nor",     3'b100, 32'd5,        32'd9,  0, 0, 32'hFFFFFFF2,  4'b0010);
    run("sl",      3'b101, 32'd7,        32'd12, 0, 0, 32'h00007000,  4'b0000);
    run("sr",      3'b110, 32'd7,        32'd12, 0, 0, 32'd0,         4'b0100);
    run("sra",     3'b111, 32'h80000000, 32'd4,  0, 0, 32'hF8000000,  4'b0010);
    run("sra31",   3'b111, 32'h80000000, 32'd31, 0, 0, 32'hFFFFFFFF,  4'b0010);
    run("slmod",   3'b101, 32'd7,        32'h20, 0, 0, 32'd7,         4'b0000);
    run("srmod",   3'b110, 32'h80000000, 32'hFFFFFFE1, 0, 0, 32'h40000000, 4'b0000);
    run("ovf",     3'b000, 32'h7FFFFFFF, 32'd1,  0, 0, 32'h80000000,  4'b0011);
    run("wrap",    3'b000, 32'hFFFFFFFF, 32'd1,  0, 0, 32'd0,         4'b1100);
    run("subovf",  3'b000, 32'h80000000, 32'd1,  0, 1, 32'h7FFFFFFF,  4'b1001);
    run("addneg",  3'b000, 32'h80000000, 32'h80000000, 0, 0, 32'd0,   4'b1101);

    // Reset mid-stream with live operands wins over the computation.
    run("pre",     3'b011, 32'h12345678, 32'h0, 0, 0, 32'h12345678,  4'b0000);
    rst = 1'b1;
    run("midrst",  3'b000, 32'd5,        32'd10, 0, 0, 32'd0,         4'b0000);
    rst = 1'b0;
    run("postrst", 3'b000, 32'd5,        32'd10, 0, 0, 32'd15,        4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
